// File: rtl/srv_icb_pkg.sv
// Shared ICB types, widths and arbiter lock-state encoding for the srv ICB fabric.
package srv_icb_pkg;

    localparam int unsigned W_ADDR = 32;
    localparam int unsigned W_DATA = 32;
    localparam int unsigned W_MASK = W_DATA / 8;
    localparam int unsigned W_CMD  = W_ADDR + 1 + W_DATA + W_MASK;
    localparam int unsigned W_RESP = W_DATA + 1;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              read;
        logic [W_DATA-1:0] wdata;
        logic [W_MASK-1:0] wmask;
    } icb_cmd_t;

    typedef struct packed {
        logic [W_DATA-1:0] rdata;
        logic              err;
    } icb_resp_t;

    typedef enum logic {
        LOCK_OFF,
        LOCK_ON
    } lock_state_e;

    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
        return aw + 1 + dw + dw / 8;
    endfunction

endpackage

// File: rtl/srv_rr_arb.sv
// One-hot request arbiter with grant lock; round-robin by default,
// fixed lowest-index priority when SRV_ICB_NV1_FIXED_PRIO_EN is defined.
module srv_rr_arb
    import srv_icb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         stall,
    input  logic         adv,
    output logic [N-1:0] grant
);

    logic [N-1:0] pick;
    logic [N-1:0] held_q;
    lock_state_e  state_q, state_d;

`ifdef SRV_ICB_NV1_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && pick == '0) pick[i] = 1'b1;
        end
    end
`else
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned idx;
        idx  = 0;
        pick = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (req[idx] && pick == '0) pick[idx] = 1'b1;
        end
    end

    // Pointer moves to one past whoever actually handshook, locked or not.
    always_comb begin
        ptr_d = ptr_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)    ptr_q <= '0;
        else if (adv) ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant   = pick;
        case (state_q)
            LOCK_OFF: if (stall) state_d = LOCK_ON;
            LOCK_ON: begin
                grant = held_q;
                if (adv) state_d = LOCK_OFF;
            end
            default: state_d = LOCK_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOCK_OFF;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOCK_OFF && stall) held_q <= pick;
        end
    end

endmodule

// File: rtl/srv_sync_fifo.sv
// Synchronous circular FIFO with occupancy counter; flush clears it like reset.
module srv_sync_fifo #(
    parameter int unsigned DP = 2,
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int unsigned AW = (DP > 1) ? $clog2(DP) : 1;
    localparam int unsigned CW = $clog2(DP + 1);

    logic [DW-1:0] mem [DP];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DP - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DP));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_q];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= inc(wr_q);
            if (do_pop)  rd_q <= inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/srv_icb_nv1_arb.sv
// N-to-1 ICB arbiter: grants one upstream master onto the downstream port and
// routes in-order responses back via an order FIFO. Option: SRV_ICB_NV1_FIXED_PRIO_EN.
module srv_icb_nv1_arb
    import srv_icb_pkg::*;
#(
    parameter int unsigned G_US_NUM = 2,
    parameter int unsigned G_W_ADDR = W_ADDR,
    parameter int unsigned G_W_DATA = W_DATA,
    parameter int unsigned G_MPX    = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    output logic                                  active,
    input  logic [G_US_NUM-1:0]                   us_cmd_valid,
    output logic [G_US_NUM-1:0]                   us_cmd_ready,
    input  logic [G_US_NUM-1:0][G_W_ADDR-1:0]     us_cmd_addr,
    input  logic [G_US_NUM-1:0]                   us_cmd_read,
    input  logic [G_US_NUM-1:0][G_W_DATA-1:0]     us_cmd_wdata,
    input  logic [G_US_NUM-1:0][G_W_DATA/8-1:0]   us_cmd_wmask,
    output logic [G_US_NUM-1:0]                   us_resp_valid,
    input  logic [G_US_NUM-1:0]                   us_resp_ready,
    output logic [G_US_NUM-1:0][G_W_DATA-1:0]     us_resp_rdata,
    output logic [G_US_NUM-1:0]                   us_resp_err,
    output logic                                  ds_cmd_valid,
    input  logic                                  ds_cmd_ready,
    output logic [G_W_ADDR-1:0]                   ds_cmd_addr,
    output logic                                  ds_cmd_read,
    output logic [G_W_DATA-1:0]                   ds_cmd_wdata,
    output logic [G_W_DATA/8-1:0]                 ds_cmd_wmask,
    input  logic                                  ds_resp_valid,
    output logic                                  ds_resp_ready,
    input  logic [G_W_DATA-1:0]                   ds_resp_rdata,
    input  logic                                  ds_resp_err
);

    localparam int unsigned WC = cmd_width(G_W_ADDR, G_W_DATA);

    logic [G_US_NUM-1:0]         grant, head;
    logic [G_US_NUM-1:0][WC-1:0] us_cmd_flat;
    logic [WC-1:0]               ds_cmd_flat;
    logic                        fifo_full, fifo_empty;
    logic                        cmd_hs, cmd_stall, resp_hs;

    assign ds_cmd_valid = (|us_cmd_valid) & ~fifo_full;
    assign cmd_hs       = ds_cmd_valid & ds_cmd_ready;
    assign cmd_stall    = ds_cmd_valid & ~ds_cmd_ready;
    assign us_cmd_ready = grant & {G_US_NUM{ds_cmd_ready & ~fifo_full}};

    srv_rr_arb #(
        .N (G_US_NUM)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (us_cmd_valid),
        .stall (cmd_stall),
        .adv   (cmd_hs),
        .grant (grant)
    );

    always_comb begin
        ds_cmd_flat = '0;
        for (int unsigned i = 0; i < G_US_NUM; i++) begin
            us_cmd_flat[i] = {us_cmd_addr[i], us_cmd_read[i], us_cmd_wdata[i], us_cmd_wmask[i]};
            if (grant[i]) ds_cmd_flat = ds_cmd_flat | us_cmd_flat[i];
        end
    end

    assign {ds_cmd_addr, ds_cmd_read, ds_cmd_wdata, ds_cmd_wmask} = ds_cmd_flat;

    srv_sync_fifo #(
        .DP (G_MPX),
        .DW (G_US_NUM)
    ) u_order_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (cmd_hs),
        .din   (grant),
        .pop   (resp_hs),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Head entry is only trusted while non-empty; stale storage never leaks out.
    assign us_resp_valid = head & {G_US_NUM{ds_resp_valid & ~fifo_empty}};
    assign ds_resp_ready = ~fifo_empty & (|(head & us_resp_ready));
    assign resp_hs       = ds_resp_valid & ds_resp_ready;
    assign active        = ~fifo_empty;

    always_comb begin
        for (int unsigned i = 0; i < G_US_NUM; i++) begin
            us_resp_rdata[i] = ds_resp_rdata;
        end
    end

    assign us_resp_err = {G_US_NUM{ds_resp_err}};

endmodule

// File: tb/tb_srv_icb_nv1_arb.sv
// Directed bench for srv_icb_nv1_arb with a queue-based reference model checked every cycle.
module tb_srv_icb_nv1_arb;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MPX = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     active;
    logic [N-1:0]             us_cmd_valid, us_cmd_ready;
    logic [N-1:0][AW-1:0]     us_cmd_addr;
    logic [N-1:0]             us_cmd_read;
    logic [N-1:0][DW-1:0]     us_cmd_wdata;
    logic [N-1:0][DW/8-1:0]   us_cmd_wmask;
    logic [N-1:0]             us_resp_valid, us_resp_ready;
    logic [N-1:0][DW-1:0]     us_resp_rdata;
    logic [N-1:0]             us_resp_err;
    logic                     ds_cmd_valid, ds_cmd_ready;
    logic [AW-1:0]            ds_cmd_addr;
    logic                     ds_cmd_read;
    logic [DW-1:0]            ds_cmd_wdata;
    logic [DW/8-1:0]          ds_cmd_wmask;
    logic                     ds_resp_valid, ds_resp_ready;
    logic [DW-1:0]            ds_resp_rdata;
    logic                     ds_resp_err;

    always #5 clk = ~clk;

    srv_icb_nv1_arb #(
        .G_US_NUM (N),
        .G_W_ADDR (AW),
        .G_W_DATA (DW),
        .G_MPX    (MPX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .active        (active),
        .us_cmd_valid  (us_cmd_valid),
        .us_cmd_ready  (us_cmd_ready),
        .us_cmd_addr   (us_cmd_addr),
        .us_cmd_read   (us_cmd_read),
        .us_cmd_wdata  (us_cmd_wdata),
        .us_cmd_wmask  (us_cmd_wmask),
        .us_resp_valid (us_resp_valid),
        .us_resp_ready (us_resp_ready),
        .us_resp_rdata (us_resp_rdata),
        .us_resp_err   (us_resp_err),
        .ds_cmd_valid  (ds_cmd_valid),
        .ds_cmd_ready  (ds_cmd_ready),
        .ds_cmd_addr   (ds_cmd_addr),
        .ds_cmd_read   (ds_cmd_read),
        .ds_cmd_wdata  (ds_cmd_wdata),
        .ds_cmd_wmask  (ds_cmd_wmask),
        .ds_resp_valid (ds_resp_valid),
        .ds_resp_ready (ds_resp_ready),
        .ds_resp_rdata (ds_resp_rdata),
        .ds_resp_err   (ds_resp_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: list of owners awaiting responses, next-preferred master, held grant.
    int q[$];
    int ptr_m   = 0;
    int held    = -1;
    bit model_on = 1'b0;

    initial begin
        int        g, idx;
        bit        ev, rr, cmd_hs, stall, resp_hs, rst_s;
        logic [N-1:0] rdy_e, rv_e;
        forever begin
            @(negedge clk);
            rst_s = reset;
            g = -1;
            if (held >= 0) g = held;
            else begin
                for (int k = 0; k < N; k++) begin
`ifdef SRV_ICB_NV1_FIXED_PRIO_EN
                    idx = k;
`else
                    idx = (ptr_m + k) % N;
`endif
                    if (g < 0 && us_cmd_valid[idx]) g = idx;
                end
            end
            ev    = (us_cmd_valid != '0) && (q.size() < MPX);
            rdy_e = '0;
            if (ev && ds_cmd_ready) rdy_e[g] = 1'b1;
            rv_e  = '0;
            if (ds_resp_valid && q.size() > 0) rv_e[q[0]] = 1'b1;
            rr    = (q.size() > 0) && us_resp_ready[q[0]];
            if (model_on) begin
                check("m_ds_cmd_valid", ds_cmd_valid, ev);
                check("m_us_cmd_ready", us_cmd_ready, rdy_e);
                if (ev)
                    check("m_ds_cmd_payload", {ds_cmd_read, ds_cmd_addr, ds_cmd_wdata, ds_cmd_wmask},
                          {us_cmd_read[g], us_cmd_addr[g], us_cmd_wdata[g], us_cmd_wmask[g]});
                check("m_us_resp_valid", us_resp_valid, rv_e);
                check("m_ds_resp_ready", ds_resp_ready, rr);
                check("m_active", active, q.size() > 0);
                if (rv_e != '0)
                    check("m_resp_payload", {us_resp_err[q[0]], us_resp_rdata[q[0]]},
                          {ds_resp_err, ds_resp_rdata});
            end
            cmd_hs  = ev && ds_cmd_ready;
            stall   = ev && !ds_cmd_ready;
            resp_hs = ds_resp_valid && rr;
            @(posedge clk);
            if (rst_s) begin
                q.delete();
                ptr_m    = 0;
                held     = -1;
                model_on = 1'b1;
            end else if (model_on) begin
                if (resp_hs) void'(q.pop_front());
                if (cmd_hs) begin
                    q.push_back(g);
                    ptr_m = (g + 1) % N;
                    held  = -1;
                end else if (stall && held < 0) begin
                    held = g;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        us_cmd_valid  = '0;
        us_cmd_addr   = '0;
        us_cmd_read   = '0;
        us_cmd_wdata  = '0;
        us_cmd_wmask  = '0;
        us_resp_ready = '1;
        ds_cmd_ready  = 1'b1;
        ds_resp_valid = 1'b1;
        ds_resp_rdata = '0;
        ds_resp_err   = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state, with a stray response already on the bus.
        at_neg();
        check("rst_active", active, 1'b0);
        check("rst_ds_resp_ready", ds_resp_ready, 1'b0);
        check("rst_us_resp_valid", us_resp_valid, 2'b00);

        // 1: single master read.
        step();
        ds_resp_valid  = 1'b0;
        us_cmd_valid   = 2'b01;
        us_cmd_addr[0] = 32'h100;
        us_cmd_read[0] = 1'b1;
        at_neg();
        check("t1_ds_cmd_addr", ds_cmd_addr, 32'h100);
        check("t1_us_cmd_ready", us_cmd_ready, 2'b01);
        step();
        us_cmd_valid  = '0;
        ds_resp_valid = 1'b1;
        ds_resp_rdata = 32'hDEADBEEF;
        at_neg();
        check("t1_us_resp_valid", us_resp_valid, 2'b01);
        check("t1_rdata", us_resp_rdata[0], 32'hDEADBEEF);
        check("t1_active_busy", active, 1'b1);
        step();
        ds_resp_valid = 1'b0;
        at_neg();
        check("t1_active_idle", active, 1'b0);

        // 2: contention, round-robin alternation from reset.
        step();
        do_reset();
        us_cmd_valid   = 2'b11;
        us_cmd_addr[0] = 32'h200;
        us_cmd_addr[1] = 32'h300;
        us_cmd_read    = 2'b10;
        us_cmd_wdata[0] = 32'h0123_4567;
        us_cmd_wmask[0] = 4'hF;
        ds_resp_valid  = 1'b1;
        ds_resp_rdata  = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check("t2_grant", us_cmd_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("t2_addr", ds_cmd_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
            step();
        end
        us_cmd_valid = '0;
        step();
        ds_resp_valid = 1'b0;
        at_neg();
        check("t2_drained", active, 1'b0);

        // 3: lock holds us0 while the higher-priority us1 shows up.
        step();
        do_reset();
        us_cmd_valid   = 2'b01;
        us_cmd_addr[0] = 32'h40;
        step();
        us_cmd_valid  = '0;
        ds_resp_valid = 1'b1;
        step();
        ds_resp_valid  = 1'b0;
        us_cmd_valid   = 2'b01;
        us_cmd_addr[0] = 32'hA0;
        us_cmd_addr[1] = 32'hB0;
        ds_cmd_ready   = 1'b0;
        at_neg();
        check("t3_first_addr", ds_cmd_addr, 32'hA0);
        step();
        us_cmd_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("t3_locked_addr", ds_cmd_addr, 32'hA0);
            check("t3_locked_ready", us_cmd_ready, 2'b00);
            step();
        end
        ds_cmd_ready = 1'b1;
        at_neg();
        check("t3_release_ready", us_cmd_ready, 2'b01);
        step();
        us_cmd_valid = 2'b10;
        at_neg();
        check("t3_next_addr", ds_cmd_addr, 32'hB0);
        step();
        us_cmd_valid  = '0;
        ds_resp_valid = 1'b1;
        step();
        step();
        ds_resp_valid = 1'b0;
        at_neg();
        check("t3_drained", active, 1'b0);

        // 4: order FIFO full blocks commands, even on the popping cycle.
        step();
        do_reset();
        us_cmd_valid   = 2'b11;
        us_cmd_addr[0] = 32'h400;
        us_cmd_addr[1] = 32'h500;
        at_neg();
        check("t4_acc0", us_cmd_ready, 2'b01);
        step();
        at_neg();
        check("t4_acc1", us_cmd_ready, 2'b10);
        step();
        at_neg();
        check("t4_full_valid", ds_cmd_valid, 1'b0);
        check("t4_full_ready", us_cmd_ready, 2'b00);
        step();
        ds_resp_valid = 1'b1;
        at_neg();
        check("t4_pop_full_ready", us_cmd_ready, 2'b00);
        check("t4_pop_resp_ready", ds_resp_ready, 1'b1);
        step();
        at_neg();
        check("t4_freed_ready", us_cmd_ready, 2'b01);
        step();
        us_cmd_valid = '0;
        step();
        ds_resp_valid = 1'b0;
        at_neg();
        check("t4_drained", active, 1'b0);

        // 5: responses return in command order; a stalled owner stalls downstream.
        step();
        do_reset();
        us_cmd_valid   = 2'b10;
        us_cmd_addr[1] = 32'h11;
        at_neg();
        check("t5_cmd_us1", us_cmd_ready, 2'b10);
        step();
        us_cmd_valid   = 2'b01;
        us_cmd_addr[0] = 32'h22;
        at_neg();
        check("t5_cmd_us0", us_cmd_ready, 2'b01);
        step();
        us_cmd_valid  = '0;
        us_resp_ready = 2'b01;
        ds_resp_valid = 1'b1;
        ds_resp_rdata = 32'hAAAA_0001;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            check("t5_a_owner", us_resp_valid, 2'b10);
            check("t5_a_stall", ds_resp_ready, 1'b0);
            step();
        end
        us_resp_ready = 2'b11;
        at_neg();
        check("t5_a_ready", ds_resp_ready, 1'b1);
        check("t5_a_rdata", us_resp_rdata[1], 32'hAAAA_0001);
        step();
        ds_resp_rdata = 32'hBBBB_0002;
        ds_resp_err   = 1'b1;
        at_neg();
        check("t5_b_owner", us_resp_valid, 2'b01);
        check("t5_b_rdata", {us_resp_err[0], us_resp_rdata[0]}, {1'b1, 32'hBBBB_0002});
        step();
        ds_resp_valid = 1'b0;
        ds_resp_err   = 1'b0;
        at_neg();
        check("t5_drained", active, 1'b0);

        // 6: reset discards outstanding entries; late response is held off.
        step();
        do_reset();
        us_cmd_valid = 2'b11;
        step();
        step();
        us_cmd_valid = '0;
        reset        = 1'b1;
        at_neg();
        check("t6_pre_reset_active", active, 1'b1);
        step();
        reset         = 1'b0;
        ds_resp_valid = 1'b1;
        at_neg();
        check("t6_ds_resp_ready", ds_resp_ready, 1'b0);
        check("t6_active", active, 1'b0);
        check("t6_us_resp_valid", us_resp_valid, 2'b00);
        step();
        ds_resp_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
